// File: rtl/dct_odd.sv
// rtl/dct_odd.sv - odd-half row of an 8-point DCT butterfly, one odd output per phase
// Stage 1 registers the four differences and phase; stage 2 forms the selected row sum.
module dct_odd #(
  parameter logic [19:0] c1 = 20'd514214,
  parameter logic [19:0] c2 = 20'd435930,
  parameter logic [19:0] c3 = 20'd291278,
  parameter logic [19:0] c4 = 20'd102284,
  parameter int CNT_CLK = 1,
  parameter int cu = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cnt_clk,
  input  logic [23:0] a0,
  input  logic [23:0] a1,
  input  logic [23:0] a2,
  input  logic [23:0] a3,
  input  logic [23:0] a4,
  input  logic [23:0] a5,
  input  logic [23:0] a6,
  input  logic [23:0] a7,
  output logic [23:0] c
);

  localparam int SHIFT = 19 + cu;
  localparam logic [4:0] BASE = 5'(CNT_CLK);
  localparam logic signed [47:0] SAT_MAX = 48'sd8388607;
  localparam logic signed [47:0] SAT_MIN = -48'sd8388608;

  logic [4:0] phase_off;
  logic       phase_ok;

  // An unknown cnt_clk makes the compare unknown, which falls through to idle.
  always_comb begin
    phase_off = {1'b0, cnt_clk} - BASE;
    phase_ok  = 1'b0;
    if (phase_off < 5'd4) phase_ok = 1'b1;
  end

  logic signed [24:0] d0_q, d1_q, d2_q, d3_q;
  logic               valid_q;
  logic [1:0]         phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      valid_q <= 1'b0;
      phase_q <= 2'd0;
    end else begin
      d0_q    <= $signed({a0[23], a0}) - $signed({a7[23], a7});
      d1_q    <= $signed({a1[23], a1}) - $signed({a6[23], a6});
      d2_q    <= $signed({a2[23], a2}) - $signed({a5[23], a5});
      d3_q    <= $signed({a3[23], a3}) - $signed({a4[23], a4});
      valid_q <= phase_ok;
      phase_q <= phase_off[1:0];
    end
  end

  logic signed [20:0] k0, k1, k2, k3;
  logic               neg1, neg2, neg3;

  // Coefficients stay positive; the row signs are applied after multiplication.
  always_comb begin
    k0   = {1'b0, c1};
    k1   = {1'b0, c2};
    k2   = {1'b0, c3};
    k3   = {1'b0, c4};
    neg1 = 1'b0;
    neg2 = 1'b0;
    neg3 = 1'b0;
    case (phase_q)
      2'd1: begin
        k0 = {1'b0, c2}; k1 = {1'b0, c4}; k2 = {1'b0, c1}; k3 = {1'b0, c3};
        neg1 = 1'b1; neg2 = 1'b1; neg3 = 1'b1;
      end
      2'd2: begin
        k0 = {1'b0, c3}; k1 = {1'b0, c1}; k2 = {1'b0, c4}; k3 = {1'b0, c2};
        neg1 = 1'b1;
      end
      2'd3: begin
        k0 = {1'b0, c4}; k1 = {1'b0, c3}; k2 = {1'b0, c2}; k3 = {1'b0, c1};
        neg1 = 1'b1; neg3 = 1'b1;
      end
      default: ;
    endcase
  end

  logic signed [45:0] m0, m1, m2, m3;

  assign m0 = 46'(d0_q) * 46'(k0);
  assign m1 = 46'(d1_q) * 46'(k1);
  assign m2 = 46'(d2_q) * 46'(k2);
  assign m3 = 46'(d3_q) * 46'(k3);

  logic signed [47:0] sum, scaled;
  logic [23:0]        sat;

  always_comb begin
    sum = 48'(m0)
        + (neg1 ? -48'(m1) : 48'(m1))
        + (neg2 ? -48'(m2) : 48'(m2))
        + (neg3 ? -48'(m3) : 48'(m3));
    scaled = sum >>> SHIFT;
    if (scaled > SAT_MAX)      sat = 24'h7fffff;
    else if (scaled < SAT_MIN) sat = 24'h800000;
    else                       sat = scaled[23:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       c <= '0;
    else if (valid_q) c <= sat;
  end

endmodule

// File: tb/tb_dct_odd.sv
// tb/tb_dct_odd.sv - directed bench for dct_odd: default, unit-c1 and unit-c1 cu=1 variants
module tb_dct_odd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cnt_clk = 4'd0;
  logic [23:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0;
  logic [23:0] a4 = '0, a5 = '0, a6 = '0, a7 = '0;
  logic [23:0] c_def, c_one, c_cu1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dct_odd u_def (
    .clk(clk), .rst_n(rst_n), .cnt_clk(cnt_clk),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .c(c_def)
  );

  dct_odd #(.c1(20'd524288), .c2(20'd0), .c3(20'd0), .c4(20'd0), .CNT_CLK(1), .cu(0)) u_one (
    .clk(clk), .rst_n(rst_n), .cnt_clk(cnt_clk),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .c(c_one)
  );

  dct_odd #(.c1(20'd524288), .c2(20'd0), .c3(20'd0), .c4(20'd0), .CNT_CLK(1), .cu(1)) u_cu1 (
    .clk(clk), .rst_n(rst_n), .cnt_clk(cnt_clk),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
    .c(c_cu1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int v0, input int v1, input int v2, input int v3,
                       input int v4, input int v5, input int v6, input int v7);
    a0 = 24'(v0); a1 = 24'(v1); a2 = 24'(v2); a3 = 24'(v3);
    a4 = 24'(v4); a5 = 24'(v5); a6 = 24'(v6); a7 = 24'(v7);
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input int exp);
    logic signed [23:0] expv;
    expv = 24'(exp);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), expv);
    end
  endtask

  initial begin
    // reset held with nonzero inputs and a valid phase
    set_a(5, 6, 7, 8, 1, 2, 3, 4);
    cnt_clk = 4'd1;
    step();
    step();
    check("reset_def", c_def, 0);
    check("reset_one", c_one, 0);
    cnt_clk = 4'd0;
    rst_n = 1'b1;
    step();
    check("post_rel_1", c_def, 0);
    step();
    check("post_rel_2", c_one, 0);

    // single tap, X1 then X5
    set_a(100, 0, 0, 0, 0, 0, 0, 0);
    cnt_clk = 4'd1;
    step(); step();
    check("x1_one", c_one, 100);
    check("x1_def", c_def, 98);
    check("x1_cu1", c_cu1, 50);
    cnt_clk = 4'd3;
    step(); step();
    check("x5_one_zero", c_one, 0);
    check("x5_def", c_def, 55);

    // sign/row: a4 only gives d3 = -100
    set_a(0, 0, 0, 0, 100, 0, 0, 0);
    cnt_clk = 4'd4;
    step(); step();
    check("x7_one", c_one, 100);
    check("x7_def", c_def, 98);
    cnt_clk = 4'd2;
    step(); step();
    check("x3_one_zero", c_one, 0);
    check("x3_def", c_def, 55);
    cnt_clk = 4'd1;
    step(); step();
    check("x1_floor_def", c_def, -20);

    // saturation
    set_a(8388607, 0, 0, 0, 0, 0, 0, -8388608);
    cnt_clk = 4'd1;
    step(); step();
    check("sat_pos_one", c_one, 8388607);
    check("sat_pos_cu1", c_cu1, 8388607);
    check("sat_pos_def", c_def, 8388607);
    set_a(-8388608, 0, 0, 0, 0, 0, 0, 8388607);
    step(); step();
    check("sat_neg_one", c_one, -8388608);
    check("sat_neg_cu1", c_cu1, -8388608);

    // back-to-back phases then idle
    set_a(10, 20, 30, 40, 0, 0, 0, 0);
    cnt_clk = 4'd1; step();
    cnt_clk = 4'd2; step();
    check("pipe_x1_one", c_one, 10);
    check("pipe_x1_def", c_def, 50);
    cnt_clk = 4'd3; step();
    check("pipe_x3_one", c_one, -30);
    check("pipe_x3_def", c_def, -48);
    cnt_clk = 4'd4; step();
    check("pipe_x5_one", c_one, -20);
    check("pipe_x5_def", c_def, 25);
    cnt_clk = 4'd0; step();
    check("pipe_x7_one", c_one, -40);
    check("pipe_x7_def", c_def, -24);
    set_a(1, 2, 3, 4, 5, 6, 7, 8);
    step();
    check("idle_hold_1", c_def, -24);
    cnt_clk = 4'bxxxx;
    step(); step();
    check("idle_hold_x", c_def, -24);
    check("idle_hold_x_one", c_one, -40);

    // symmetric input gives zero on every phase
    set_a(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
    cnt_clk = 4'd1; step();
    cnt_clk = 4'd2; step();
    check("sym_x1", c_def, 0);
    cnt_clk = 4'd3; step();
    check("sym_x3", c_def, 0);
    cnt_clk = 4'd4; step();
    check("sym_x5", c_def, 0);
    cnt_clk = 4'd0; step();
    check("sym_x7", c_def, 0);

    // reset mid-flight discards the pending result
    set_a(100, 0, 0, 0, 0, 0, 0, 0);
    cnt_clk = 4'd1;
    step(); step();
    check("pre_rst_one", c_one, 100);
    set_a(200, 0, 0, 0, 0, 0, 0, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_one", c_one, 0);
    check("async_rst_def", c_def, 0);
    cnt_clk = 4'd0;
    step();
    rst_n = 1'b1;
    step();
    check("discard_1", c_one, 0);
    step();
    check("discard_2", c_one, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
